layer_mem_arbiter: RTL
======================

LAYER_MEM_ARBITER -- requirements
Module: layer_mem_arbiter

Interface
REQ-001 The block SHALL expose the parameter ADDR_W, default 12, layer-memory address width.
REQ-002 The block SHALL expose the parameter DATA_W, default 20, layer-memory data width.
REQ-003 The block SHALL expose the parameter MAX_BURST, default 64, maximum locked commands per grant.
REQ-004 The block SHALL have the port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have the ports req[2:0], input, 3, per-requester request (0=conv, 1=pool, 2=flatten).
REQ-007 The block SHALL have the ports lock[2:0], input, 3, per-requester request to keep the grant for a burst.
REQ-008 The block SHALL have the ports wr[2:0], input, 3, per-requester command type (1=write, 0=read).
REQ-009 The block SHALL have the ports sel0/sel1/sel2, input, 3 each, per-requester target memory select.
REQ-010 The block SHALL have the ports addr0/addr1/addr2, input, ADDR_W each, per-requester command address.
REQ-011 The block SHALL have the ports wdata0/wdata1/wdata2, input, DATA_W each, per-requester write data.
REQ-012 The block SHALL have the port gnt[2:0], output, 3, registered one-hot grant.
REQ-013 The block SHALL have the port rvalid[2:0], output, 3, read-return strobe to the requester.
REQ-014 The block SHALL have the port rdata, output, DATA_W, registered read data broadcast to all requesters.
REQ-015 The block SHALL have the ports cwr and crd, output, 1 each, memory write and read strobes.
REQ-016 The block SHALL have the port csel, output, 3, memory select.
REQ-017 The block SHALL have the ports caddr_wr and caddr_rd, output, ADDR_W each, memory write and read addresses.
REQ-018 The block SHALL have the port cdata_wr, output, DATA_W, memory write data.
REQ-019 The block SHALL have the port cdata_rd, input, DATA_W, memory read data, valid in the cycle crd is high.
REQ-020 The block SHALL have the port err, output, 1, sticky illegal-select flag.

Function
REQ-021 FSM states SHALL be ARB and OWN; in ARB, gnt=0 and no command is issued.
REQ-022 In ARB with any req high, the round-robin pick SHALL start from rr_ptr; next cycle gnt is one-hot to the winner and the state is OWN.
REQ-023 In OWN, each cycle with req[g] high SHALL be a command cycle for granted requester g.
REQ-024 A command SHALL be registered onto the memory port the next cycle: wr=1 -> cwr=1, crd=0, caddr_wr=addr, cdata_wr=wdata; wr=0 -> crd=1, cwr=0, caddr_rd=addr; csel=sel.
REQ-025 With no command, cwr=crd=0 and addresses/data/csel SHALL hold their values.
REQ-026 When crd is high, rdata SHALL capture cdata_rd and rvalid[g] SHALL pulse next cycle (read latency 2 cycles from command cycle).
REQ-027 Legal sel values SHALL be 1..5; sel 0, 6 or 7 SHALL drop the command (no strobe) and set err, which stays high until reset.
REQ-028 In OWN, req[g] low SHALL cause gnt to clear next cycle, the state to return to ARB, and rr_ptr to become g+1 mod 3.
REQ-029 A command issued with lock[g] low while another req is high SHALL release the grant after that command (ARB next cycle, rr_ptr=g+1).
REQ-030 With lock[g] low and no other requester pending, the grant SHALL be held.
REQ-031 The burst counter SHALL count commands per grant; reaching MAX_BURST with another req pending SHALL force release after that command; the counter clears on every grant.
REQ-032 Requests arriving in ARB simultaneously SHALL be resolved by round-robin only; a requester SHALL never wait more than 2 other grants.
REQ-033 A write followed by a read to the same address SHALL be ordered; the read returns the new data.

Reset
REQ-034 Reset low SHALL immediately force state ARB, rr_ptr=0, gnt=0, rvalid=0, cwr=crd=0, csel=0, caddr_wr=caddr_rd=0, cdata_wr=0, rdata=0, err=0, burst counter=0.
REQ-035 Reset mid-burst SHALL discard in-flight reads with no rvalid issued.

Structure
REQ-036 Package cnn_mem_pkg SHALL hold requester IDs, csel encodings (L0_K0=1, L0_K1=2, L1_K0=3, L1_K1=4, L2=5), ADDR_W/DATA_W defaults, MAX_BURST and the FSM state type.
REQ-037 The round-robin selection SHALL be the sub-module rr_picker (3 requests plus pointer in, one-hot out).

Verification
REQ-038 Single read: conv req=1, wr=0, sel=1, addr=0x041, memory returns 0x12345 -> crd=1, caddr_rd=0x041 two cycles after req; rvalid[0]=1 with rdata=0x12345 one cycle later.
REQ-039 Contention: req=3'b111, lock=0, rr_ptr=0 -> grants in order 0, 1, 2, 0 with one ARB gap between each.
REQ-040 Lock burst: pool locked for 100 writes with flatten requesting -> exactly 64 writes, then gnt moves to 2.
REQ-041 Illegal select: sel=0 write -> no cwr pulse, err=1 held until reset.
REQ-042 Reset mid-burst: reset low during OWN with a read outstanding -> all outputs 0 asynchronously, no rvalid; after release, first grant goes to requester 0.
REQ-043 Write-then-read: 0x00ABC written to sel=3, addr=5, then read -> rdata=0x00ABC.

Source files
------------

// File: rtl/cnn_mem_pkg.sv
// cnn_mem_pkg
//   Shared definitions for the layer-memory arbiter: requester IDs, memory
//   select encodings, parameter defaults, arbiter FSM state type and small
//   helpers for requester-index arithmetic.
package cnn_mem_pkg;

  // Requester IDs (bit position in req/lock/wr/gnt/rvalid)
  localparam logic [1:0] REQ_CONV    = 2'd0;
  localparam logic [1:0] REQ_POOL    = 2'd1;
  localparam logic [1:0] REQ_FLATTEN = 2'd2;
  localparam int         NUM_REQ     = 3;

  // Memory select encodings; 0, 6 and 7 are illegal
  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    L0_K0    = 3'd1,
    L0_K1    = 3'd2,
    L1_K0    = 3'd3,
    L1_K1    = 3'd4,
    L2       = 3'd5
  } csel_t;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_DATA_W    = 20;
  localparam int DEF_MAX_BURST = 64;

  typedef enum logic {
    ARB = 1'b0,
    OWN = 1'b1
  } arb_state_t;

  // Next requester index in round-robin order (2 wraps to 0)
  function automatic logic [1:0] next_id(input logic [1:0] id);
    return (id >= 2'd2) ? 2'd0 : id + 2'd1;
  endfunction

  // One-hot grant to requester index
  function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
    if (oh[2])      return 2'd2;
    else if (oh[1]) return 2'd1;
    else            return 2'd0;
  endfunction

  function automatic logic sel_legal(input logic [2:0] s);
    return (s >= L0_K0) && (s <= L2);
  endfunction

endpackage

// File: rtl/layer_mem_arbiter_rr_picker.sv
// rr_picker
//   Combinational round-robin pick among three requesters.
//   Ports:
//     req [2:0] - request vector
//     ptr [1:0] - index that gets first priority (3 is treated as 0)
//     gnt [2:0] - one-hot winner, all zero when no request
module rr_picker
  import cnn_mem_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt
);

  logic [1:0] base;
  logic [1:0] idx [NUM_REQ];
  logic [2:0] hit;

  assign base = (ptr > 2'd2) ? 2'd0 : ptr;

  // idx[gi] is the requester examined at priority position gi
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pos
      if (gi == 0) begin : g_first
        assign idx[gi] = base;
      end else begin : g_rest
        assign idx[gi] = next_id(idx[gi-1]);
      end
      assign hit[gi] = req[idx[gi]];
    end
  endgenerate

  always_comb begin
    gnt = '0;
    if (hit[0])      gnt[idx[0]] = 1'b1;
    else if (hit[1]) gnt[idx[1]] = 1'b1;
    else if (hit[2]) gnt[idx[2]] = 1'b1;
  end

endmodule

// File: rtl/layer_mem_arbiter.sv
// layer_mem_arbiter
//   Arbitrates three CNN layer engines (conv, pool, flatten) onto a single
//   layer-memory command port. A grant is taken in ARB and held in OWN; each
//   OWN cycle with the owner's req high issues one command, registered onto
//   the memory port the following cycle. Reads return rdata/rvalid one cycle
//   after the crd strobe.
//   Ports:
//     clk, reset            - clock, asynchronous active-low reset
//     req/lock/wr [2:0]     - per-requester request, burst lock, write(1)/read(0)
//     sel0..2, addr0..2,
//     wdata0..2             - per-requester command fields
//     gnt [2:0]             - registered one-hot grant
//     rvalid [2:0], rdata   - read return strobe per requester, shared data
//     cwr, crd, csel,
//     caddr_wr, caddr_rd,
//     cdata_wr              - memory command port
//     cdata_rd              - memory read data, valid while crd is high
//     err                   - sticky illegal-select flag
module layer_mem_arbiter
  import cnn_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [2:0]        lock,
  input  logic [2:0]        wr,
  input  logic [2:0]        sel0,
  input  logic [2:0]        sel1,
  input  logic [2:0]        sel2,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] wdata2,
  output logic [2:0]        gnt,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              cwr,
  output logic              crd,
  output logic [2:0]        csel,
  output logic [ADDR_W-1:0] caddr_wr,
  output logic [ADDR_W-1:0] caddr_rd,
  output logic [DATA_W-1:0] cdata_wr,
  input  logic [DATA_W-1:0] cdata_rd,
  output logic              err
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  // FSM / arbitration state
  arb_state_t        state_reg, state_next;
  logic [1:0]        owner_reg, owner_next;
  logic [1:0]        rr_ptr_reg, rr_ptr_next;
  logic [2:0]        gnt_reg, gnt_next;
  logic [CNT_W-1:0]  burst_cnt_reg, burst_cnt_next;

  // Memory port / return path registers
  logic              cwr_reg, crd_reg;
  logic [2:0]        csel_reg;
  logic [ADDR_W-1:0] caddr_wr_reg, caddr_rd_reg;
  logic [DATA_W-1:0] cdata_wr_reg;
  logic [1:0]        rd_owner_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic [2:0]        rvalid_reg;
  logic              err_reg;

  // Per-requester command fields gathered for indexing by owner
  logic [2:0]        sel_arr   [NUM_REQ];
  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  assign sel_arr[0]   = sel0;
  assign sel_arr[1]   = sel1;
  assign sel_arr[2]   = sel2;
  assign addr_arr[0]  = addr0;
  assign addr_arr[1]  = addr1;
  assign addr_arr[2]  = addr2;
  assign wdata_arr[0] = wdata0;
  assign wdata_arr[1] = wdata1;
  assign wdata_arr[2] = wdata2;

  logic [2:0]        pick;
  logic [2:0]        cmd_sel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              cmd_wr;
  logic              cmd_cycle;
  logic              cmd_legal;
  logic              others_pending;
  logic              burst_last;
  logic              release_grant;

  rr_picker u_rr_picker (
    .req (req),
    .ptr (rr_ptr_reg),
    .gnt (pick)
  );

  assign cmd_sel   = sel_arr[owner_reg];
  assign cmd_addr  = addr_arr[owner_reg];
  assign cmd_wdata = wdata_arr[owner_reg];
  assign cmd_wr    = wr[owner_reg];

  assign cmd_cycle      = (state_reg == OWN) && req[owner_reg];
  assign cmd_legal      = cmd_cycle && sel_legal(cmd_sel);
  // gnt_reg is one-hot to the owner while in OWN, so masking it leaves the rivals
  assign others_pending = |(req & ~gnt_reg);
  assign burst_last     = (burst_cnt_reg >= CNT_LAST);

  // Owner dropping req always releases; otherwise give way to a waiting
  // rival after an unlocked command or after the last command of a burst.
  assign release_grant = (state_reg == OWN) &&
                         (!req[owner_reg] ||
                          (others_pending && (!lock[owner_reg] || burst_last)));

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    rr_ptr_next    = rr_ptr_reg;
    gnt_next       = gnt_reg;
    burst_cnt_next = burst_cnt_reg;
    case (state_reg)
      ARB: begin
        gnt_next = '0;
        if (|req) begin
          state_next     = OWN;
          gnt_next       = pick;
          owner_next     = onehot_to_id(pick);
          burst_cnt_next = '0;
        end
      end
      OWN: begin
        if (release_grant) begin
          state_next  = ARB;
          gnt_next    = '0;
          rr_ptr_next = next_id(owner_reg);
        end else if (cmd_cycle && !burst_last) begin
          // Saturates at the last slot so a late rival still forces release
          burst_cnt_next = burst_cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = ARB;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ARB;
      owner_reg     <= 2'd0;
      rr_ptr_reg    <= 2'd0;
      gnt_reg       <= '0;
      burst_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      rr_ptr_reg    <= rr_ptr_next;
      gnt_reg       <= gnt_next;
      burst_cnt_reg <= burst_cnt_next;
    end
  end

  // Memory command register stage and read return
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cwr_reg      <= 1'b0;
      crd_reg      <= 1'b0;
      csel_reg     <= '0;
      caddr_wr_reg <= '0;
      caddr_rd_reg <= '0;
      cdata_wr_reg <= '0;
      rd_owner_reg <= 2'd0;
      rdata_reg    <= '0;
      rvalid_reg   <= '0;
      err_reg      <= 1'b0;
    end else begin
      cwr_reg <= cmd_legal && cmd_wr;
      crd_reg <= cmd_legal && !cmd_wr;
      if (cmd_legal) begin
        csel_reg <= cmd_sel;
        if (cmd_wr) begin
          caddr_wr_reg <= cmd_addr;
          cdata_wr_reg <= cmd_wdata;
        end else begin
          caddr_rd_reg <= cmd_addr;
          rd_owner_reg <= owner_reg;
        end
      end
      if (cmd_cycle && !cmd_legal) begin
        err_reg <= 1'b1;
      end
      rvalid_reg <= '0;
      if (crd_reg) begin
        rdata_reg  <= cdata_rd;
        rvalid_reg <= 3'b001 << rd_owner_reg;
      end
    end
  end

  assign gnt      = gnt_reg;
  assign rvalid   = rvalid_reg;
  assign rdata    = rdata_reg;
  assign cwr      = cwr_reg;
  assign crd      = crd_reg;
  assign csel     = csel_reg;
  assign caddr_wr = caddr_wr_reg;
  assign caddr_rd = caddr_rd_reg;
  assign cdata_wr = cdata_wr_reg;
  assign err      = err_reg;

endmodule
